// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Purpose  : Serial-to-parallel UART receiver for 8N1 / 8O1 / 8E1 frames.
//            A 2-FF synchronizer feeds a mid-bit sampling FSM. Each frame
//            ends with a one-cycle data_valid strobe, accompanied by the
//            data word and the parity and framing status.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int COUNTS_PER_BIT  = 434,
    parameter int DATA_BITS       = 8,
    parameter int CLOCK_CTR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           parity_type,
    input  logic                 serial_data_in,
    output logic [DATA_BITS-1:0] parallel_out,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 framing_error
);

    localparam int c_IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CLOCK_CTR_WIDTH-1:0] c_CPB_M1   = CLOCK_CTR_WIDTH'(COUNTS_PER_BIT - 1);
    localparam logic [CLOCK_CTR_WIDTH-1:0] c_HALF_M1  = CLOCK_CTR_WIDTH'(COUNTS_PER_BIT / 2 - 1);
    localparam logic [CLOCK_CTR_WIDTH-1:0] c_CTR_ZERO = '0;
    localparam logic [CLOCK_CTR_WIDTH-1:0] c_CTR_ONE  = CLOCK_CTR_WIDTH'(1);
    localparam logic [c_IDX_W-1:0]         c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0]         c_IDX_ZERO = '0;
    localparam logic [c_IDX_W-1:0]         c_IDX_ONE  = c_IDX_W'(1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_START     = 3'd1;
    localparam logic [2:0] c_ST_DATA      = 3'd2;
    localparam logic [2:0] c_ST_PARITY    = 3'd3;
    localparam logic [2:0] c_ST_STOP      = 3'd4;
    localparam logic [2:0] c_ST_WAIT_HIGH = 3'd5;

    logic                       r_sync1;
    logic                       r_rx_s;
    logic [2:0]                 r_state;
    logic [2:0]                 w_next_state;
    logic [CLOCK_CTR_WIDTH-1:0] r_bit_ctr;
    logic [c_IDX_W-1:0]         r_bit_idx;
    logic [DATA_BITS-1:0]       r_shift;
    logic [1:0]                 r_mode;
    logic                       r_par_bit;
    logic [DATA_BITS-1:0]       r_parallel;
    logic                       r_valid;
    logic                       r_par_err;
    logic                       r_frm_err;

    logic w_bit_hit;
    logic w_half_hit;
    logic w_parity_en;
    logic w_sample;
    logic w_frame_done;
    logic w_par_err;

    assign w_bit_hit   = (r_bit_ctr == c_CPB_M1);
    assign w_half_hit  = (r_bit_ctr == c_HALF_M1);
    assign w_parity_en = (r_mode == 2'd1) || (r_mode == 2'd2);

    // Bring the asynchronous line into the clock domain; reset to idle-high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= serial_data_in;
            r_rx_s  <= r_sync1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic plus the sample and frame-done qualifiers.
    always_comb begin
        w_next_state = r_state;
        w_sample     = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!r_rx_s) w_next_state = c_ST_START;
            end
            c_ST_START: begin
                if (w_half_hit) begin
                    w_sample     = 1'b1;
                    w_next_state = r_rx_s ? c_ST_IDLE : c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_bit_hit) begin
                    w_sample = 1'b1;
                    if (r_bit_idx == c_IDX_LAST) begin
                        w_next_state = w_parity_en ? c_ST_PARITY : c_ST_STOP;
                    end
                end
            end
            c_ST_PARITY: begin
                if (w_bit_hit) begin
                    w_sample     = 1'b1;
                    w_next_state = c_ST_STOP;
                end
            end
            c_ST_STOP: begin
                if (w_bit_hit) begin
                    w_sample     = 1'b1;
                    w_frame_done = 1'b1;
                    // A low stop bit parks the FSM until the line recovers,
                    // so a held break yields a single strobe.
                    w_next_state = r_rx_s ? c_ST_IDLE : c_ST_WAIT_HIGH;
                end
            end
            c_ST_WAIT_HIGH: begin
                if (r_rx_s) w_next_state = c_ST_IDLE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Parity verdict for the frame being closed; mode 0 and 3 never flag.
    always_comb begin
        w_par_err = 1'b0;
        if (r_mode == 2'd1) begin
            w_par_err = ~((^r_shift) ^ r_par_bit);
        end else if (r_mode == 2'd2) begin
            w_par_err = (^r_shift) ^ r_par_bit;
        end
    end

    // Bit-period counter, bit index, shift register and parity-mode latch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bit_ctr <= c_CTR_ZERO;
            r_bit_idx <= c_IDX_ZERO;
            r_shift   <= '0;
            r_mode    <= 2'd0;
            r_par_bit <= 1'b0;
        end else begin
            if (r_state == c_ST_IDLE || r_state == c_ST_WAIT_HIGH || w_sample) begin
                r_bit_ctr <= c_CTR_ZERO;
            end else begin
                r_bit_ctr <= r_bit_ctr + c_CTR_ONE;
            end

            if (r_state == c_ST_IDLE) begin
                r_bit_idx <= c_IDX_ZERO;
                // Mode is frozen for the whole frame once the start edge is seen.
                if (!r_rx_s) r_mode <= parity_type;
            end

            if (r_state == c_ST_DATA && w_bit_hit) begin
                r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                r_bit_idx <= (r_bit_idx == c_IDX_LAST) ? c_IDX_ZERO : r_bit_idx + c_IDX_ONE;
            end

            if (r_state == c_ST_PARITY && w_bit_hit) begin
                r_par_bit <= r_rx_s;
            end
        end
    end

    // Output registers: all status updates together with the one-cycle strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_parallel <= '0;
            r_valid    <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_valid <= w_frame_done;
            if (w_frame_done) begin
                r_parallel <= r_shift;
                r_par_err  <= w_par_err;
                r_frm_err  <= ~r_rx_s;
            end
        end
    end

    assign parallel_out  = r_parallel;
    assign data_valid    = r_valid;
    assign parity_error  = r_par_err;
    assign framing_error = r_frm_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Purpose  : Directed bench for uart_receiver with a behavioural TX model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int c_CPB = 16;

    logic       clk;
    logic       rst;
    logic [1:0] parity_type;
    logic       serial_data_in;
    logic [7:0] parallel_out;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;

    int checks;
    int errors;
    int cyc;
    int last_start_cyc;

    int         q_cyc[$];
    logic [7:0] q_data[$];
    logic       q_perr[$];
    logic       q_ferr[$];

    uart_receiver #(
        .COUNTS_PER_BIT (c_CPB),
        .DATA_BITS      (8),
        .CLOCK_CTR_WIDTH(32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .parity_type   (parity_type),
        .serial_data_in(serial_data_in),
        .parallel_out  (parallel_out),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter, advanced on every active edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            q_cyc.push_back(cyc);
            q_data.push_back(parallel_out);
            q_perr.push_back(parity_error);
            q_ferr.push_back(framing_error);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        q_cyc.delete();
        q_data.delete();
        q_perr.delete();
        q_ferr.delete();
    endtask

    task automatic send_bit(input logic b);
        serial_data_in = b;
        idle(c_CPB);
    endtask

    // One frame: start, 8 data bits LSB first, optional parity, stop.
    task automatic tx_frame(input logic [7:0] d, input logic has_par,
                            input logic par_bit, input logic stop_bit);
        last_start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (has_par) send_bit(par_bit);
        send_bit(stop_bit);
    endtask

    // Check the entry at index k of the strobe log.
    task automatic check_strobe(input string tag, input int k, input logic [7:0] d,
                                input logic pe, input logic fe);
        if (q_data.size() > k) begin
            check({tag, "_data"}, {24'd0, q_data[k]}, {24'd0, d});
            check({tag, "_perr"}, {31'd0, q_perr[k]}, {31'd0, pe});
            check({tag, "_ferr"}, {31'd0, q_ferr[k]}, {31'd0, fe});
        end else begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        int t_first;
        checks = 0;
        errors = 0;
        cyc = 0;
        last_start_cyc = 0;
        rst = 1'b0;
        parity_type = 2'd0;
        serial_data_in = 1'b1;
        idle(3);

        check("rst_data", {24'd0, parallel_out}, 32'd0);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_perr", {31'd0, parity_error}, 32'd0);
        check("rst_ferr", {31'd0, framing_error}, 32'd0);

        rst = 1'b1;
        idle(5);
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(5);

        // 8N1 0xA5 plus strobe timing relative to the pin edge.
        clear_log();
        tx_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(20);
        check("n81_count", q_cyc.size(), 32'd1);
        check_strobe("n81", 0, 8'hA5, 1'b0, 1'b0);
        if (q_cyc.size() > 0) check("n81_latency", q_cyc[0] - last_start_cyc, 32'd155);

        // 8O1 0x37 correct parity, then 8E1 0x37 with a wrong parity bit.
        clear_log();
        parity_type = 2'd1;
        tx_frame(8'h37, 1'b1, 1'b0, 1'b1);
        idle(20);
        parity_type = 2'd2;
        tx_frame(8'h37, 1'b1, 1'b0, 1'b1);
        idle(20);
        check("par_count", q_cyc.size(), 32'd2);
        check_strobe("odd_ok", 0, 8'h37, 1'b0, 1'b0);
        check_strobe("even_bad", 1, 8'h37, 1'b1, 1'b0);

        // Break: stop bit low, then line held low for 40 bit times.
        clear_log();
        parity_type = 2'd0;
        tx_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        idle(40 * c_CPB);
        check("brk_count", q_cyc.size(), 32'd1);
        check_strobe("brk", 0, 8'h5A, 1'b0, 1'b1);
        serial_data_in = 1'b1;
        idle(20);
        check("brk_recover_count", q_cyc.size(), 32'd1);
        tx_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        idle(20);
        check("after_brk_count", q_cyc.size(), 32'd2);
        check_strobe("after_brk", 1, 8'hC3, 1'b0, 1'b0);

        // Short low glitch on an idle line is rejected.
        clear_log();
        serial_data_in = 1'b0;
        idle(5);
        serial_data_in = 1'b1;
        idle(30);
        check("glitch_count", q_cyc.size(), 32'd0);
        tx_frame(8'h01, 1'b0, 1'b0, 1'b1);
        idle(20);
        check("post_glitch_count", q_cyc.size(), 32'd1);
        check_strobe("post_glitch", 0, 8'h01, 1'b0, 1'b0);

        // Reset in the middle of data bit 4 of a 0x96 frame.
        clear_log();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        serial_data_in = 1'b1;
        idle(8);
        rst = 1'b0;
        idle(2);
        check("midrst_data", {24'd0, parallel_out}, 32'd0);
        check("midrst_valid", {31'd0, data_valid}, 32'd0);
        check("midrst_perr", {31'd0, parity_error}, 32'd0);
        check("midrst_ferr", {31'd0, framing_error}, 32'd0);
        rst = 1'b1;
        idle(12 * c_CPB);
        check("midrst_count", q_cyc.size(), 32'd0);
        tx_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        idle(20);
        check("post_rst_count", q_cyc.size(), 32'd1);
        check_strobe("post_rst", 0, 8'hFF, 1'b0, 1'b0);

        // Three back-to-back 8E1 frames with no idle gap.
        clear_log();
        parity_type = 2'd2;
        tx_frame(8'h00, 1'b1, 1'b0, 1'b1);
        tx_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        tx_frame(8'h81, 1'b1, 1'b0, 1'b1);
        idle(30);
        check("b2b_count", q_cyc.size(), 32'd3);
        check_strobe("b2b0", 0, 8'h00, 1'b0, 1'b0);
        check_strobe("b2b1", 1, 8'hFF, 1'b0, 1'b0);
        check_strobe("b2b2", 2, 8'h81, 1'b0, 1'b0);
        if (q_cyc.size() == 3) begin
            t_first = q_cyc[0];
            check("b2b_gap1", q_cyc[1] - t_first, 32'd176);
            check("b2b_gap2", q_cyc[2] - q_cyc[1], 32'd176);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
